// File: rtl/fetch_unit.sv
`default_nettype none
//==============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: owns the PC, issues one outstanding
//               memory read at a time and hands instructions to decode.
// Revision    : 1.0 - initial release
//==============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_pc_inc = 1;

    state_t               r_state;
    state_t               w_state_next;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_next;
    logic [INSTR_W-1:0]   r_instruction;
    logic [ADDR_W-1:0]    r_instr_pc;
    logic                 w_capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_instruction <= '0;
            r_instr_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_capture) begin
                r_instruction <= mem_rdata;
                r_instr_pc    <= r_pc;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_capture    = 1'b0;

        case (r_state)
            S_BOOT:  w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_capture    = 1'b1;
                    w_pc_next    = r_pc + c_pc_inc;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD:  if (instr_ready) w_state_next = S_ISSUE;
            S_DRAIN: if (mem_rvalid)  w_state_next = S_ISSUE;
            default: w_state_next = S_BOOT;
        endcase

        // A redirect drops any response landing this cycle; DRAIN is only
        // needed while a request is still unanswered.
        if (redirect) begin
            w_pc_next = redirect_pc;
            w_capture = 1'b0;
            case (r_state)
                S_ISSUE: w_state_next = S_DRAIN;
                S_WAIT:  w_state_next = mem_rvalid ? S_ISSUE : S_DRAIN;
                S_DRAIN: w_state_next = mem_rvalid ? S_ISSUE : S_DRAIN;
                default: w_state_next = S_ISSUE;
            endcase
        end
    end

    assign mem_req     = (r_state == S_ISSUE);
    assign mem_addr    = r_pc;
    assign instr_valid = (r_state == S_HOLD);
    assign instruction = r_instruction;
    assign instr_pc    = r_instr_pc;
    assign pc          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [7:0]  instr_pc;
    logic [7:0]  pc;

    int n_tests = 0;
    int n_fail  = 0;
    logic auto_mem;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; the 1-cycle memory answers a request seen at this edge.
    task automatic tick();
        logic       req_prev;
        logic [7:0] addr_prev;
        req_prev  = mem_req;
        addr_prev = mem_addr;
        @(posedge clk);
        #1;
        mem_rvalid = auto_mem && req_prev;
        mem_rdata  = 16'h1000 + {8'h00, addr_prev};
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   {31'd0, mem_req},     32'd0);
        check({tag, "_addr"},  {24'd0, mem_addr},    32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_instr"}, {16'd0, instruction}, 32'd0);
        check({tag, "_ipc"},   {24'd0, instr_pc},    32'd0);
        check({tag, "_pc"},    {24'd0, pc},          32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = 16'h0000;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        instr_ready = 1'b1;
        auto_mem    = 1'b1;

        tick();
        tick();
        check_reset_vals("reset");

        // Release reset: BOOT then ISSUE of address 0
        reset = 1'b0;
        tick();
        check("boot_req", {31'd0, mem_req}, 32'd1);

        // Streaming with ready high: ISSUE, WAIT, HOLD per instruction
        for (int k = 0; k < 4; k++) begin
            check("st_req",   {31'd0, mem_req},  32'd1);
            check("st_addr",  {24'd0, mem_addr}, k);
            tick();
            check("st_wait_req",   {31'd0, mem_req},     32'd0);
            check("st_wait_valid", {31'd0, instr_valid}, 32'd0);
            tick();
            check("st_valid", {31'd0, instr_valid}, 32'd1);
            check("st_instr", {16'd0, instruction}, 32'h1000 + k);
            check("st_ipc",   {24'd0, instr_pc},    k);
            check("st_pc",    {24'd0, pc},          k + 1);
            tick();
            check("st_drop",  {31'd0, instr_valid}, 32'd0);
        end

        // Backpressure: five cycles stalled in HOLD
        instr_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_instr", {16'd0, instruction}, 32'h1004);
            check("bp_ipc",   {24'd0, instr_pc},    32'h04);
            check("bp_req",   {31'd0, mem_req},     32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        check("bp_next_req",  {31'd0, mem_req},  32'd1);
        check("bp_next_addr", {24'd0, mem_addr}, 32'h05);

        // Redirect in WAIT to 0x40, stale response two cycles later
        auto_mem = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        check("rw_pc",    {24'd0, pc},          32'h40);
        check("rw_req",   {31'd0, mem_req},     32'd0);
        check("rw_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("rw_drain_req",   {31'd0, mem_req},     32'd0);
        check("rw_drain_valid", {31'd0, instr_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        auto_mem   = 1'b1;
        tick();
        check("rw_issue_req",   {31'd0, mem_req},     32'd1);
        check("rw_issue_addr",  {24'd0, mem_addr},    32'h40);
        check("rw_issue_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        tick();
        check("rw_valid2", {31'd0, instr_valid}, 32'd1);
        check("rw_instr",  {16'd0, instruction}, 32'h1040);
        check("rw_ipc",    {24'd0, instr_pc},    32'h40);

        // Redirect in HOLD with ready high to 0x10: no DRAIN
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        tick();
        redirect = 1'b0;
        check("rh_valid", {31'd0, instr_valid}, 32'd0);
        check("rh_req",   {31'd0, mem_req},     32'd1);
        check("rh_addr",  {24'd0, mem_addr},    32'h10);
        tick();
        tick();
        check("rh_instr", {16'd0, instruction}, 32'h1010);
        check("rh_ipc",   {24'd0, instr_pc},    32'h10);

        // Wrap: redirect to 0xFF
        redirect    = 1'b1;
        redirect_pc = 8'hFF;
        tick();
        redirect = 1'b0;
        check("wr_addr", {24'd0, mem_addr}, 32'hFF);
        tick();
        tick();
        check("wr_valid", {31'd0, instr_valid}, 32'd1);
        check("wr_instr", {16'd0, instruction}, 32'h10FF);
        check("wr_ipc",   {24'd0, instr_pc},    32'hFF);
        check("wr_pc",    {24'd0, pc},          32'h00);
        tick();
        check("wr_next_req",  {31'd0, mem_req},  32'd1);
        check("wr_next_addr", {24'd0, mem_addr}, 32'h00);

        // Reset asserted in HOLD, late response during BOOT ignored
        tick();
        tick();
        check("rst_hold_pre", {31'd0, instr_valid}, 32'd1);
        reset = 1'b1;
        tick();
        check_reset_vals("rst_hold");
        reset      = 1'b0;
        auto_mem   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        tick();
        check("boot_late_req",   {31'd0, mem_req},     32'd1);
        check("boot_late_instr", {16'd0, instruction}, 32'd0);
        check("boot_late_pc",    {24'd0, pc},          32'd0);

        // Reset asserted in DRAIN
        tick();
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        tick();
        redirect = 1'b0;
        check("rst_drain_pre", {24'd0, pc}, 32'h20);
        reset = 1'b1;
        tick();
        check_reset_vals("rst_drain");
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        auto_mem   = 1'b1;
        tick();
        check("rd_boot_req",   {31'd0, mem_req},     32'd1);
        check("rd_boot_valid", {31'd0, instr_valid}, 32'd0);
        check("rd_boot_instr", {16'd0, instruction}, 32'd0);
        tick();
        tick();
        check("rd_fetch_instr", {16'd0, instruction}, 32'h1000);
        check("rd_fetch_ipc",   {24'd0, instr_pc},    32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
